vlc_tree_walker: RTL

Parametrised variable-length-code decoder for the slice/block decode path. It walks a binary code tree stored in an external synchronous table ROM, consuming one bitstream bit per node. It selects one of up to four tables per symbol and returns the leaf word together with the code length. Compared with the single-table, bit-serial coefficient decoder it adds bitstream and output handshakes, back-pressure, code-length reporting and a depth-overflow error.

---
 rtl/vlc_tree_walker.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/vlc_tree_walker.sv
// Variable-length-code decoder: walks a binary code tree held in an external synchronous ROM,
// one bitstream bit per node, with bit/output handshakes and a depth-overflow error.
module vlc_tree_walker #(
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned ADDR_W      = 10,
    parameter int unsigned MAX_DEPTH   = 16,
    parameter int unsigned TABLE0_BASE = 0,
    parameter int unsigned TABLE1_BASE = 256,
    parameter int unsigned TABLE2_BASE = 512,
    parameter int unsigned TABLE3_BASE = 768
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              Start_I,
    input  logic [1:0]        Table_Sel_I,
    input  logic              Bit_I,
    input  logic              Bit_Valid_I,
    output logic              Bit_Ack_O,
    output logic              Valid_O,
    input  logic              Ready_I,
    output logic [DATA_W-1:0] Symbol_O,
    output logic [5:0]        Length_O,
    output logic              Error_O,
    output logic              Busy_O,
    output logic              Table_En_O,
    output logic [ADDR_W-1:0] Table_Addr_O,
    input  logic [DATA_W-1:0] Table_Data_I
);
    localparam int unsigned NODE_W = DATA_W / 2;

    typedef enum logic [1:0] {StIdle, StWalk, StHold, StErr} state_e;

    state_e            state_q;
    logic [1:0]        sel_q;
    logic [5:0]        depth_q;
    logic [ADDR_W-1:0] addr_q;
    logic              valid_q;
    logic              error_q;
    logic [DATA_W-1:0] symbol_q;
    logic [5:0]        length_q;

    logic [NODE_W-1:0] node;
    logic              node_leaf;
    logic [NODE_W-2:0] node_off;
    logic [5:0]        depth_inc;
    logic              depth_last;
    logic [ADDR_W-1:0] child_addr;
    logic              walk_bit;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;

    function automatic logic [ADDR_W-1:0] base_of(input logic [1:0] sel);
        case (sel)
            2'd0:    return ADDR_W'(TABLE0_BASE);
            2'd1:    return ADDR_W'(TABLE1_BASE);
            2'd2:    return ADDR_W'(TABLE2_BASE);
            default: return ADDR_W'(TABLE3_BASE);
        endcase
    endfunction

    always_comb begin
        node       = Bit_I ? Table_Data_I[DATA_W-1:NODE_W] : Table_Data_I[NODE_W-1:0];
        node_leaf  = node[NODE_W-1];
        node_off   = node[NODE_W-2:0];
        depth_inc  = depth_q + 6'd1;
        depth_last = 32'(depth_inc) >= MAX_DEPTH;
        // Address arithmetic wraps modulo 2^ADDR_W by construction.
        child_addr = base_of(sel_q) + ADDR_W'(node_off);
        walk_bit   = (state_q == StWalk) && Bit_Valid_I && !Start_I;

        rd_en   = 1'b0;
        rd_addr = addr_q;
        if (Start_I) begin
            rd_en   = 1'b1;
            rd_addr = base_of(Table_Sel_I);
        end else if (walk_bit && !node_leaf && !depth_last) begin
            rd_en   = 1'b1;
            rd_addr = child_addr;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q  <= StIdle;
            sel_q    <= 2'd0;
            depth_q  <= 6'd0;
            addr_q   <= '0;
            valid_q  <= 1'b0;
            error_q  <= 1'b0;
            symbol_q <= '0;
            length_q <= 6'd0;
        end else begin
            if (rd_en) begin
                addr_q <= rd_addr;
            end
            if (Start_I) begin
                // Start wins in every state, including an in-flight walk.
                state_q <= StWalk;
                sel_q   <= Table_Sel_I;
                depth_q <= 6'd0;
                valid_q <= 1'b0;
                error_q <= 1'b0;
            end else begin
                case (state_q)
                    StWalk: begin
                        if (Bit_Valid_I) begin
                            depth_q <= depth_inc;
                            if (node_leaf) begin
                                symbol_q <= Table_Data_I;
                                length_q <= depth_inc;
                                valid_q  <= 1'b1;
                                state_q  <= StHold;
                            end else if (depth_last) begin
                                error_q  <= 1'b1;
                                length_q <= 6'(MAX_DEPTH);
                                state_q  <= StErr;
                            end
                        end
                    end
                    StHold: begin
                        if (Ready_I) begin
                            valid_q <= 1'b0;
                            state_q <= StIdle;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Gating with resetn keeps the ROM and bitstream quiet while reset is held.
    assign Table_En_O   = rd_en && resetn;
    assign Table_Addr_O = rd_addr;
    assign Bit_Ack_O    = walk_bit && resetn;
    assign Busy_O       = (state_q == StWalk);
    assign Valid_O      = valid_q;
    assign Error_O      = error_q;
    assign Symbol_O     = symbol_q;
    assign Length_O     = length_q;

endmodule
